// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_param
// Description : Coin-operated vending controller. It accepts 1/2/5-yuan coin
//               pulses and accumulates credit against PRICE. When the credit
//               reaches PRICE it vends, then returns any change. It refunds
//               on cancel or on inactivity timeout, and rejects coins it
//               cannot accept. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_param #(
  parameter int PRICE   = 6,
  parameter int SUM_W   = 5,
  parameter int TIMEOUT = 1000,
  parameter int TMR_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_1yuan,
  input  logic             i_2yuan,
  input  logic             i_5yuan,
  input  logic             i_cancel,
  output logic             o_done,
  output logic [SUM_W-1:0] o_change,
  output logic             o_change_vld,
  output logic             o_refund,
  output logic             o_reject,
  output logic [SUM_W-1:0] o_credit,
  output logic             o_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VEND    = 3'd2;
  localparam logic [2:0] S_CHANGE  = 3'd3;
  localparam logic [2:0] S_REFUND  = 3'd4;

  localparam logic [SUM_W-1:0] PRICE_V    = SUM_W'(PRICE);
  localparam logic [TMR_W-1:0] TMO_LAST_V = TMR_W'(TIMEOUT - 1);

  logic [2:0]       state, next_state;
  logic [SUM_W-1:0] credit, next_credit;
  logic [TMR_W-1:0] timer, next_timer;

  logic             d_done, d_change_vld, d_refund, d_reject;
  logic [SUM_W-1:0] d_change;

  logic [1:0]       coin_cnt;
  logic             coin_ok, coin_multi, coin_any;
  logic [SUM_W-1:0] coin_val, credit_sum;

  // Classify the coin inputs: a single coin is valid, more than one is rejected.
  always_comb begin
    coin_cnt   = {1'b0, i_1yuan} + {1'b0, i_2yuan} + {1'b0, i_5yuan};
    coin_ok    = (coin_cnt == 2'd1);
    coin_multi = coin_cnt[1];
    coin_any   = i_1yuan | i_2yuan | i_5yuan;
    coin_val   = '0;
    if (i_1yuan) coin_val = SUM_W'(1);
    if (i_2yuan) coin_val = SUM_W'(2);
    if (i_5yuan) coin_val = SUM_W'(5);
    // Credit stays below PRICE in COLLECT, so the sum never exceeds PRICE+4.
    credit_sum = credit + coin_val;
  end

  // Next-state, credit, timer and output computation.
  always_comb begin
    next_state   = state;
    next_credit  = credit;
    next_timer   = '0;
    d_done       = 1'b0;
    d_change     = '0;
    d_change_vld = 1'b0;
    d_refund     = 1'b0;
    d_reject     = coin_multi;
    case (state)
      S_IDLE: begin
        if (coin_ok) begin
          next_credit = coin_val;
          next_state  = (coin_val >= PRICE_V) ? S_VEND : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (coin_ok) begin
          // The coin is accumulated first; vend has priority over cancel.
          next_credit = credit_sum;
          if (credit_sum >= PRICE_V) begin
            next_state = S_VEND;
          end else if (i_cancel) begin
            next_state = S_REFUND;
          end
        end else if (i_cancel) begin
          next_state = S_REFUND;
        end else if (timer == TMO_LAST_V) begin
          next_state = S_REFUND;
        end else begin
          next_timer = timer + TMR_W'(1);
        end
      end
      S_VEND: begin
        d_reject = coin_any;
        d_done   = 1'b1;
        if (credit > PRICE_V) begin
          next_state = S_CHANGE;
        end else begin
          next_state  = S_IDLE;
          next_credit = '0;
        end
      end
      S_CHANGE: begin
        d_reject     = coin_any;
        d_change     = credit - PRICE_V;
        d_change_vld = 1'b1;
        next_credit  = '0;
        next_state   = S_IDLE;
      end
      S_REFUND: begin
        d_reject     = coin_any;
        d_change     = credit;
        d_change_vld = 1'b1;
        d_refund     = 1'b1;
        next_credit  = '0;
        next_state   = S_IDLE;
      end
      default: begin
        next_state  = S_IDLE;
        next_credit = '0;
      end
    endcase
  end

  // State, credit, timer and registered outputs; reset discards all credit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      timer        <= '0;
      o_done       <= 1'b0;
      o_change     <= '0;
      o_change_vld <= 1'b0;
      o_refund     <= 1'b0;
      o_reject     <= 1'b0;
    end else begin
      state        <= next_state;
      credit       <= next_credit;
      timer        <= next_timer;
      o_done       <= d_done;
      o_change     <= d_change;
      o_change_vld <= d_change_vld;
      o_refund     <= d_refund;
      o_reject     <= d_reject;
    end
  end

  assign o_credit = credit;
  assign o_busy   = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl_param
// Description : Directed self-checking bench for vend_ctrl_param using
//               PRICE=6 and TIMEOUT=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_param;

  localparam int SUM_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             c1 = 1'b0, c2 = 1'b0, c5 = 1'b0, cancel = 1'b0;
  logic             done, change_vld, refund, reject, busy;
  logic [SUM_W-1:0] change, credit;

  int checks = 0;
  int errors = 0;

  vend_ctrl_param #(
    .PRICE(6), .SUM_W(SUM_W), .TIMEOUT(8), .TMR_W(10)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_1yuan      (c1),
    .i_2yuan      (c2),
    .i_5yuan      (c5),
    .i_cancel     (cancel),
    .o_done       (done),
    .o_change     (change),
    .o_change_vld (change_vld),
    .o_refund     (refund),
    .o_reject     (reject),
    .o_credit     (credit),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then return 1 ns after it.
  task automatic step(input logic a1, input logic a2, input logic a5, input logic ac);
    c1 = a1; c2 = a2; c5 = a5; cancel = ac;
    @(posedge clk);
    #1;
    c1 = 1'b0; c2 = 1'b0; c5 = 1'b0; cancel = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_vld", 32'(change_vld), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_reject", 32'(reject), 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Cancel in IDLE is ignored
    step(0, 0, 0, 1);
    chk("idle_cancel_busy", 32'(busy), 0);
    chk("idle_cancel_vld", 32'(change_vld), 0);

    // Exact payment 1,2,2,1
    step(1, 0, 0, 0); chk("t1_credit1", 32'(credit), 1); chk("t1_busy", 32'(busy), 1);
    step(0, 1, 0, 0); chk("t1_credit3", 32'(credit), 3);
    step(0, 1, 0, 0); chk("t1_credit5", 32'(credit), 5);
    step(1, 0, 0, 0); chk("t1_credit6", 32'(credit), 6); chk("t1_done_early", 32'(done), 0);
    step(0, 0, 0, 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_credit0", 32'(credit), 0);
    chk("t1_novld", 32'(change_vld), 0);
    step(0, 0, 0, 0);
    chk("t1_done_low", 32'(done), 0);
    chk("t1_novld2", 32'(change_vld), 0);
    chk("t1_idle", 32'(busy), 0);

    // Overpayment 2,5 -> change 1
    step(0, 1, 0, 0);
    step(0, 0, 1, 0); chk("t2_credit7", 32'(credit), 7);
    step(0, 0, 0, 0);
    chk("t2_done", 32'(done), 1);
    chk("t2_vld_early", 32'(change_vld), 0);
    step(0, 0, 0, 0);
    chk("t2_done_low", 32'(done), 0);
    chk("t2_vld", 32'(change_vld), 1);
    chk("t2_change", 32'(change), 1);
    chk("t2_refund", 32'(refund), 0);
    chk("t2_credit0", 32'(credit), 0);
    step(0, 0, 0, 0);
    chk("t2_vld_low", 32'(change_vld), 0);
    chk("t2_idle", 32'(busy), 0);

    // Cancel after 2,2 -> refund 4
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("t3_vld_early", 32'(change_vld), 0);
    chk("t3_credit4", 32'(credit), 4);
    step(0, 0, 0, 0);
    chk("t3_vld", 32'(change_vld), 1);
    chk("t3_change", 32'(change), 4);
    chk("t3_refund", 32'(refund), 1);
    chk("t3_nodone", 32'(done), 0);
    step(0, 0, 0, 0);
    chk("t3_vld_low", 32'(change_vld), 0);
    chk("t3_refund_low", 32'(refund), 0);

    // Timeout: REFUND entered 8 edges after the coin, payout on the next
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("t4_vld_early", 32'(change_vld), 0);
    chk("t4_busy", 32'(busy), 1);
    step(0, 0, 0, 0);
    chk("t4_vld", 32'(change_vld), 1);
    chk("t4_change", 32'(change), 1);
    chk("t4_refund", 32'(refund), 1);
    step(0, 0, 0, 0);
    chk("t4_idle", 32'(busy), 0);

    // Timeout restarted by a coin 7 cycles after the first
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t4b_credit2", 32'(credit), 2);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    chk("t4b_vld_none", 32'(change_vld), 0);
    chk("t4b_busy", 32'(busy), 1);
    step(0, 0, 0, 0);
    chk("t4b_vld_early", 32'(change_vld), 0);
    step(0, 0, 0, 0);
    chk("t4b_vld", 32'(change_vld), 1);
    chk("t4b_change", 32'(change), 2);
    chk("t4b_refund", 32'(refund), 1);
    step(0, 0, 0, 0);

    // Simultaneous 1 and 5 in IDLE
    step(1, 0, 1, 0);
    chk("t5_reject", 32'(reject), 1);
    chk("t5_credit0", 32'(credit), 0);
    chk("t5_busy", 32'(busy), 0);
    step(0, 0, 0, 0);
    chk("t5_reject_low", 32'(reject), 0);

    // 5-yuan coin during VEND
    step(0, 0, 1, 0); chk("t5b_credit5", 32'(credit), 5);
    step(0, 1, 0, 0); chk("t5b_credit7", 32'(credit), 7);
    step(0, 0, 1, 0);
    chk("t5b_reject", 32'(reject), 1);
    chk("t5b_done", 32'(done), 1);
    chk("t5b_credit_kept", 32'(credit), 7);
    step(0, 0, 0, 0);
    chk("t5b_reject_low", 32'(reject), 0);
    chk("t5b_change", 32'(change), 1);
    chk("t5b_vld", 32'(change_vld), 1);
    step(0, 0, 0, 0);

    // Coin plus cancel reaching price: vend wins
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("t6_done", 32'(done), 1);
    step(0, 0, 0, 0);
    chk("t6_vld", 32'(change_vld), 1);
    chk("t6_change", 32'(change), 1);
    chk("t6_refund", 32'(refund), 0);
    step(0, 0, 0, 0);

    // Asynchronous reset mid-COLLECT
    step(0, 0, 1, 0);
    chk("t7_credit5", 32'(credit), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_credit0", 32'(credit), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_done", 32'(done), 0);
    chk("t7_vld", 32'(change_vld), 0);
    chk("t7_change", 32'(change), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t7_post_vld", 32'(change_vld), 0);
    chk("t7_post_busy", 32'(busy), 0);
    chk("t7_post_credit", 32'(credit), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised coin-operated vending controller. It accepts 1/2/5-yuan coin pulses, accumulates credit against a configurable price, and issues a vend pulse when credit reaches the price. It then returns change, refunds on cancel or inactivity timeout, and rejects coins it cannot accept. It sits between the coin-acceptor front end and the dispense/change-return mechanism.

Parameters:
PRICE, 6, item price in yuan; legal range 1..(2**SUM_W - 5).
SUM_W, 5, width of credit accumulator and change output; must satisfy PRICE+4 < 2**SUM_W.
TIMEOUT, 1000, cycles without a coin in COLLECT before auto-refund; legal range ≥1.
TMR_W, 10, width of inactivity counter; must satisfy TIMEOUT < 2**TMR_W.

Ports:
i_clk  input  1  system clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_1yuan  input  1  1-yuan coin, single-cycle pulse.
i_2yuan  input  1  2-yuan coin, single-cycle pulse.
i_5yuan  input  1  5-yuan coin, single-cycle pulse.
i_cancel  input  1  user cancel, single-cycle pulse.
o_done  output  1  vend pulse, 1 cycle.
o_change  output  SUM_W  change or refund amount; valid only with o_change_vld.
o_change_vld  output  1  change/refund strobe, 1 cycle.
o_refund  output  1  high with o_change_vld when the payout is a refund (cancel/timeout), not change.
o_reject  output  1  1-cycle pulse: a coin was presented but not accepted.
o_credit  output  SUM_W  current accumulated credit.
o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. All flops clear immediately on reset assertion.
- Reset state: IDLE. All outputs 0; credit 0; timer 0. Reset mid-transaction discards credit without payout.
- Outputs are registered. o_done, o_change_vld, o_refund and o_reject are exactly one cycle wide.
- Valid coin: exactly one of the coin inputs is high in a cycle.
- Multiple coin inputs high in the same cycle: none is accepted; o_reject pulses the next cycle.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND.
- IDLE:
  - Valid coin at edge k: credit <= value.
  - If value ≥ PRICE, state <= VEND; otherwise state <= COLLECT.
  - i_cancel in IDLE is ignored.
- COLLECT:
  - Valid coin: credit <= credit+value and timer <= 0.
  - If credit+value ≥ PRICE, state <= VEND.
  - Otherwise, i_cancel: state <= REFUND. A coin in the same cycle is accumulated first and included in the refund.
  - Otherwise, no coin: timer increments. When timer == TIMEOUT-1 with no coin, state <= REFUND.
  - Coin and cancel together with credit+value ≥ PRICE: vend wins; cancel is ignored.
- VEND (1 cycle):
  - o_done = 1 in the cycle after entry.
  - Next state: CHANGE if credit > PRICE, otherwise IDLE with credit <= 0.
- CHANGE (1 cycle): o_change = credit-PRICE, o_change_vld = 1, o_refund = 0. Then credit <= 0, state <= IDLE.
- REFUND (1 cycle): o_change = credit, o_change_vld = 1, o_refund = 1. Then credit <= 0, state <= IDLE.
- Coins presented in VEND, CHANGE or REFUND: not accepted, credit unchanged, o_reject pulses the next cycle. i_cancel is ignored in these states.
- Latency: coin that completes payment at edge k → o_done high during cycle k+1..k+2 → change strobe (if any) during k+2..k+3.
- Arithmetic: credit is unsigned SUM_W bits. Parameter constraints guarantee no overflow; maximum credit is PRICE+4.
- Timer: unsigned TMR_W bits, cleared outside COLLECT.

Test Plan:
- PRICE=6: coins 1,2,2,1 on separate cycles → o_done one cycle after the 4th coin; no o_change_vld; o_credit returns to 0.
- PRICE=6: coins 2,5 → o_done, then next cycle o_change=1, o_change_vld=1, o_refund=0.
- PRICE=6: coins 2,2, then i_cancel → o_change=4, o_change_vld=1, o_refund=1; no o_done.
- TIMEOUT=8: one 1-yuan coin, then idle → refund of 1 exactly 8 cycles after the coin; a coin at cycle 7 resets the count.
- i_1yuan and i_5yuan in the same cycle → o_reject pulse, credit unchanged. 5-yuan coin during VEND → o_reject, no credit change.
- PRICE=6: after coin 5, assert i_rst_n=0 mid-COLLECT without a clock edge → all outputs 0 immediately; no payout after release.
